platform_switch_debounce: RTL

- Conditions the 10 raw board slide-switch inputs before the switch PIO input port, which feeds Avalon reads.
- Per bit: 2-flop synchronizer, then a counter-based debouncer.
- Outputs the clean level plus one-cycle rise/fall pulses for downstream edge logic.
- Sits between the top-level switch pins and the PIO's in_port[9:0].

---
 rtl/platform_switch_debounce.sv | 101 ++++++++++
 1 files changed

// File: rtl/platform_switch_debounce.sv
// Switch conditioner: a 2-flop synchronizer and a counter debouncer per bit, with registered rise/fall pulses.
// Define PLATFORM_SWITCH_DEBOUNCE_EVENT_LATCH_EN to get sticky per-bit edge_flags with clr_flags.

module platform_switch_debounce_bit #(
  parameter int   DEBOUNCE_CYCLES = 50000,
  parameter int   CNT_W           = 16,
  parameter logic RESET_BIT       = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic sw_in,
  output logic level,
  output logic accept,
  output logic rise,
  output logic fall
);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1, sync2;
  logic [CNT_W-1:0] cnt;

  // The new level is taken on the edge where the counter reaches its limit.
  assign accept = (sync2 != level) && (cnt == CNT_MAX);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= RESET_BIT;
      sync2 <= RESET_BIT;
      level <= RESET_BIT;
      cnt   <= '0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      sync1 <= sw_in;
      sync2 <= sync1;
      rise  <= accept & sync2;
      fall  <= accept & ~sync2;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        level <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end
endmodule

module platform_switch_debounce #(
  parameter int               WIDTH           = 10,
  parameter int               DEBOUNCE_CYCLES = 50000,
  parameter int               CNT_W           = 16,
  parameter logic [WIDTH-1:0] RESET_VAL       = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] sw_in,
  output logic [WIDTH-1:0] sw_out,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse,
  output logic             changed,
  input  logic [WIDTH-1:0] clr_flags,
  output logic [WIDTH-1:0] edge_flags
);
  logic [WIDTH-1:0] accept;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    platform_switch_debounce_bit #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W),
      .RESET_BIT       (RESET_VAL[i])
    ) u_bit (
      .clk     (clk),
      .reset_n (reset_n),
      .sw_in   (sw_in[i]),
      .level   (sw_out[i]),
      .accept  (accept[i]),
      .rise    (rise_pulse[i]),
      .fall    (fall_pulse[i])
    );
  end

  // Registered from the same accept vector so it lines up with the pulses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) changed <= 1'b0;
    else          changed <= |accept;
  end

`ifdef PLATFORM_SWITCH_DEBOUNCE_EVENT_LATCH_EN
  // Set has priority over clear so a coincident event is never dropped.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) edge_flags <= '0;
    else          edge_flags <= accept | (edge_flags & ~clr_flags);
  end
`else
  logic unused_clr;
  assign unused_clr = ^clr_flags;
  assign edge_flags = '0;
`endif
endmodule
